// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Arbitrates two register-file writeback sources onto the single write port.
// Requester 0 is the ALU and requester 1 is the memory-load path. The grant
// (reqN_ready) is combinational in the request cycle. The accepted write is
// presented one clock later on Awr/Din/WE, with gnt recording the winner.
//
// Parameters
//   RR_EN      : 1 = round-robin between the two requesters.
//                0 = requester 0 has fixed priority, and requester 1 is
//                    force-granted after STARVE_MAX consecutive lost cycles.
//   STARVE_MAX : starvation limit, used only when RR_EN = 0.
//
// Ports
//   Clk, Reset          : clock (rising edge); asynchronous active-high reset.
//   reqN_valid/addr/data: write request from requester N (N = 0, 1).
//   reqN_ready          : combinational grant to requester N this cycle.
//   Awr, Din, WE        : registered write address, data and write enable.
//   gnt                 : registered one-hot winner of the previous edge,
//                         bit order {req1, req0}.
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
   parameter bit          RR_EN      = 1'b1,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        req0_valid,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic [4:0]  Awr,
   output logic [31:0] Din,
   output logic        WE,
   output logic [1:0]  gnt
);

   localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

   logic        last_gnt_q, last_gnt_d;     // 0 = req0 won last, 1 = req1
   logic [1:0]  starve_cnt_q, starve_cnt_d;
   logic [4:0]  awr_q, awr_d;
   logic [31:0] din_q, din_d;
   logic        we_q, we_d;
   logic [1:0]  gnt_q, gnt_d;

   logic        pick1;
   logic        xfer0, xfer1;

   // Grant selection. Requester 1 wins when it is alone, or when it is in
   // contention and either round-robin says it is its turn or, in fixed
   // priority, it has reached the starvation limit.
   always_comb begin
      pick1 = 1'b0;
      if (req1_valid) begin
         if (!req0_valid) begin
            pick1 = 1'b1;
         end else if (RR_EN) begin
            pick1 = ~last_gnt_q;
         end else begin
            pick1 = (starve_cnt_q == STARVE_LIM);
         end
      end
   end

   // Ready is forced low during reset so nothing is accepted while the
   // output registers are held clear.
   assign req1_ready = pick1 & ~Reset;
   assign req0_ready = req0_valid & ~pick1 & ~Reset;

   assign xfer0 = req0_valid & req0_ready;
   assign xfer1 = req1_valid & req1_ready;

   always_comb begin
      last_gnt_d   = last_gnt_q;
      starve_cnt_d = starve_cnt_q;
      awr_d        = awr_q;
      din_d        = din_q;
      we_d         = 1'b0;
      gnt_d        = 2'b00;

      if (xfer0) begin
         last_gnt_d = 1'b0;
         awr_d      = req0_addr;
         din_d      = req0_data;
         we_d       = (req0_addr != 5'd0);   // register 0 is hardwired zero
         gnt_d      = 2'b01;
      end else if (xfer1) begin
         last_gnt_d = 1'b1;
         awr_d      = req1_addr;
         din_d      = req1_data;
         we_d       = (req1_addr != 5'd0);
         gnt_d      = 2'b10;
      end

      // Starvation counter saturates at the limit (and at its own maximum).
      if (!req1_valid || xfer1) begin
         starve_cnt_d = 2'd0;
      end else if ((starve_cnt_q != STARVE_LIM) && (starve_cnt_q != 2'd3)) begin
         starve_cnt_d = starve_cnt_q + 2'd1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         last_gnt_q   <= 1'b1;   // so requester 0 wins the first contention
         starve_cnt_q <= 2'd0;
         awr_q        <= 5'd0;
         din_q        <= 32'd0;
         we_q         <= 1'b0;
         gnt_q        <= 2'b00;
      end else begin
         last_gnt_q   <= last_gnt_d;
         starve_cnt_q <= starve_cnt_d;
         awr_q        <= awr_d;
         din_q        <= din_d;
         we_q         <= we_d;
         gnt_q        <= gnt_d;
      end
   end

   assign Awr = awr_q;
   assign Din = din_q;
   assign WE  = we_q;
   assign gnt = gnt_q;

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority to requester 0 with a starvation limit.
REQ-002 Parameter STARVE_MAX, default 3: used only when RR_EN=0; number of consecutive lost cycles after which requester 1 is force-granted.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  ALU writeback request.
REQ-006 req0_addr  input  5  destination register.
REQ-007 req0_data  input  32  write data.
REQ-008 req0_ready  output  1  combinational grant to requester 0 in the current cycle.
REQ-009 req1_valid, req1_addr[5], req1_data[32], req1_ready: the same as REQ-005..008, for the memory-load writeback requester.
REQ-010 Awr  output  5  registered write address; drives the register-file write decoder.
REQ-011 Din  output  32  registered write data.
REQ-012 WE  output  1  registered write-enable pulse.
REQ-013 gnt  output  2  registered one-hot record of the requester accepted on the previous edge; {1,0} bit order.

Function
REQ-014 A transfer on requester N occurs on a rising edge where reqN_valid=1 and reqN_ready=1.
REQ-015 At most one of req0_ready or req1_ready shall be 1 in any cycle.
REQ-016 reqN_ready shall be 0 whenever reqN_valid=0.
REQ-017 Requester obligation, checked by the bench only: a requester holds valid, addr and data stable until the transfer occurs.
REQ-018 Single valid request: it is granted in that same cycle.
REQ-019 Both valid with RR_EN=1: grant the requester that is not last_gnt.
REQ-020 last_gnt is a 1-bit state register updated to the winner on every transfer; it holds when no transfer occurs.
REQ-021 Both valid with RR_EN=0: grant requester 0, unless starve_cnt equals STARVE_MAX, in which case grant requester 1.
REQ-022 starve_cnt is a 2-bit counter.
- Increments when req1_valid=1 and requester 1 is not granted.
- Clears when requester 1 transfers or when req1_valid=0.
- Never wraps: it holds at STARVE_MAX.
REQ-023 Latency: on the edge after a transfer, Awr and Din take the winner's address and data, and gnt takes the winner's one-hot code.
REQ-024 WE=1 for exactly one cycle per transfer, except when the accepted address is 0.
REQ-025 For an accepted address of 0: the transfer completes and gnt updates, but WE=0, because register 0 is hardwired zero.
REQ-026 On a cycle with no transfer: WE=0 and gnt=2'b00; Awr and Din hold their last values.
REQ-027 Back-to-back transfers are permitted on every cycle, giving sustained throughput of one write per cycle.
REQ-028 Same address requested by both requesters in the same cycle: the writes are serialized in grant order; the later write is the final register value.
REQ-029 The block does not merge writes or drop any request, other than the WE suppression for address 0.

Reset
REQ-030 While Reset=1 (asynchronous):
- WE=0, Awr=5'd0, Din=32'd0, gnt=2'b00.
- last_gnt=1, so requester 0 wins the first contention.
- starve_cnt=0.
- req0_ready=0 and req1_ready=0.
REQ-031 Reset asserted mid-operation aborts the pending output immediately: WE falls without waiting for a clock edge. Requests not yet transferred shall be re-presented after reset.
REQ-032 On the first rising edge after Reset deasserts, normal arbitration applies.

Verification
REQ-033 Reset asserted between edges with WE=1 -> WE=0, Awr=0, Din=0 immediately; first contention after release is won by requester 0.
REQ-034 req0 only: addr=5, data=0xDEADBEEF, valid for one cycle -> req0_ready=1 that cycle; next cycle WE=1, Awr=5, Din=0xDEADBEEF, gnt=01; following cycle WE=0.
REQ-035 RR_EN=1, both valid continuously: req0 addr 3, req1 addr 4 -> grants alternate 0,1,0,1; WE high every cycle; Awr sequence 3,4,3,4.
REQ-036 RR_EN=0, STARVE_MAX=3, both valid continuously -> grant pattern 0,0,0,1,0,0,0,1; starve_cnt returns to 0 after each req1 transfer.
REQ-037 req1 addr=0, data=0xFFFFFFFF -> req1_ready=1, next cycle gnt=10 and WE=0.
REQ-038 Both requesters target addr 7: req0 data=0x11, req1 data=0x22, fresh out of reset -> Awr=7 on two consecutive cycles with Din 0x11 then 0x22; a register model ends at 0x22.
